// File: rtl/cc_frame_feeder.sv
// cc_frame_feeder: collects one frame of 16-bit sample pairs into a block RAM,
// then sends a start pulse and streams the whole frame to the correlator with
// no gaps. It waits for cc_done before it accepts the next frame.
// Optional build macro: CC_FEEDER_OVERRUN_EN adds the overrun_cnt port and a
// saturating counter of pairs dropped while in_ready is low.
module cc_frame_feeder #(
  parameter int FRAME_LEN = 12800,
  parameter int AW        = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_m0,
  input  logic [15:0] in_m1,
  output logic        in_ready,
  input  logic        flush,
  input  logic        cc_done,
  output logic        start,
  output logic [15:0] m0,
  output logic [15:0] m1,
  output logic        stream_valid,
  output logic        busy
`ifdef CC_FEEDER_OVERRUN_EN
  ,
  output logic [15:0] overrun_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_FILL      = 2'd0,
    ST_START     = 2'd1,
    ST_STREAM    = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  // Address of the final pair in a frame, and the read count that marks the
  // last streamed sample (one extra bit so FRAME_LEN == 2^AW still works).
  localparam logic [AW-1:0] WR_LAST = AW'(FRAME_LEN - 1);
  localparam logic [AW:0]   RD_END  = (AW + 1)'(FRAME_LEN);

  state_t          state_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW:0]     rd_ptr_reg;
  logic            start_reg;
  logic            stream_valid_reg;
  logic            busy_reg;
  logic            in_ready_reg;

  logic [31:0]     frame_mem [0:(1 << AW) - 1];
  logic [31:0]     rd_data_reg;
  logic [AW-1:0]   rd_addr;
  logic            wr_en;
  logic [15:0]     chan_out [0:1];

  // in_ready_reg is only ever high in FILL, so it doubles as the write gate;
  // flush wins over a simultaneous write.
  assign wr_en   = in_ready_reg && in_valid && !flush;
  // START issues address 0; during STREAM the pointer already runs one ahead
  // of the sample on the outputs to cover the RAM read latency.
  assign rd_addr = (state_reg == ST_START) ? '0 : rd_ptr_reg[AW-1:0];

  // Frame buffer: one write port from the upstream side, registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      frame_mem[wr_ptr_reg] <= {in_m0, in_m1};
    end
    rd_data_reg <= frame_mem[rd_addr];
  end

  // Frame sequencing: fill, start pulse, gapless stream, wait for the correlator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= ST_FILL;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      start_reg        <= 1'b0;
      stream_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
      in_ready_reg     <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      case (state_reg)
        ST_FILL: begin
          in_ready_reg <= 1'b1;
          if (flush) begin
            wr_ptr_reg <= '0;
          end else if (wr_en) begin
            if (wr_ptr_reg == WR_LAST) begin
              wr_ptr_reg   <= '0;
              state_reg    <= ST_START;
              start_reg    <= 1'b1;
              busy_reg     <= 1'b1;
              in_ready_reg <= 1'b0;
            end else begin
              wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
          end
        end
        ST_START: begin
          rd_ptr_reg       <= (AW + 1)'(1);
          stream_valid_reg <= 1'b1;
          state_reg        <= ST_STREAM;
        end
        ST_STREAM: begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
          if (rd_ptr_reg == RD_END) begin
            stream_valid_reg <= 1'b0;
            state_reg        <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (cc_done) begin
            rd_ptr_reg   <= '0;
            busy_reg     <= 1'b0;
            in_ready_reg <= 1'b1;
            state_reg    <= ST_FILL;
          end
        end
        default: begin
          state_reg <= ST_FILL;
        end
      endcase
    end
  end

  // Each channel is forced to zero whenever no frame sample is on the bus.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      assign chan_out[gi] = stream_valid_reg ? rd_data_reg[16*gi +: 16] : 16'd0;
    end
  endgenerate

  assign m0           = chan_out[1];
  assign m1           = chan_out[0];
  assign start        = start_reg;
  assign stream_valid = stream_valid_reg;
  assign busy         = busy_reg;
  assign in_ready     = in_ready_reg;

`ifdef CC_FEEDER_OVERRUN_EN
  logic [15:0] overrun_reg;

  // Count pairs offered while not ready; saturates, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_reg <= '0;
    end else if (in_valid && !in_ready_reg && (overrun_reg != 16'hFFFF)) begin
      overrun_reg <= overrun_reg + 16'd1;
    end
  end

  assign overrun_cnt = overrun_reg;
`endif

endmodule

// File: tb/tb_cc_frame_feeder.sv
// Bench for cc_frame_feeder: random and ramp frames checked against a queue
// model of accepted pairs; covers flush, cc_done handling, mid-stream reset
// and (with CC_FEEDER_OVERRUN_EN) the overrun counter.
module tb_cc_frame_feeder;
  localparam int FL = 12800;
  localparam int AW = 14;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        cc_done = 1'b0;
  logic [15:0] in_m0 = 16'd0;
  logic [15:0] in_m1 = 16'd0;
  logic        in_ready;
  logic        start;
  logic        stream_valid;
  logic        busy;
  logic [15:0] m0;
  logic [15:0] m1;
`ifdef CC_FEEDER_OVERRUN_EN
  logic [15:0] overrun_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ovr = 0;
  logic [31:0] model_q[$];   // pairs accepted into the frame being filled
  logic [31:0] frame[$];     // frame expected on the stream

  always #5 clk = ~clk;

  cc_frame_feeder #(.FRAME_LEN(FL), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_m0        (in_m0),
    .in_m1        (in_m1),
    .in_ready     (in_ready),
    .flush        (flush),
    .cc_done      (cc_done),
    .start        (start),
    .m0           (m0),
    .m1           (m1),
    .stream_valid (stream_valid),
    .busy         (busy)
`ifdef CC_FEEDER_OVERRUN_EN
    ,
    .overrun_cnt  (overrun_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ovr(input string tag);
`ifdef CC_FEEDER_OVERRUN_EN
    chk(tag, overrun_cnt, exp_ovr);
`endif
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_sv"}, stream_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_m0"}, m0, 0);
    chk({tag, "_m1"}, m1, 0);
    chk_ovr({tag, "_ovr"});
  endtask

  // Assert reset mid-cycle, check outputs drop at once, then release.
  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    cc_done = 1'b0;
    exp_ovr = 0;
    model_q.delete();
    #1;
    chk_zero_outputs("rst_now");
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_zero_outputs("rst_hold");
    rst = 1'b1;
    tick();
    chk("ready_after_rst", in_ready, 1);
    $display("reset released, in_ready=%0b", in_ready);
  endtask

  // Inputs outside FILL: must be dropped; flush must be ignored.
  task automatic drive_idle(input bit hold_valid);
    in_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
    in_m0 = 16'($urandom);
    in_m1 = 16'($urandom);
    flush = 1'($urandom_range(0, 1));
    if (in_valid && exp_ovr < 65535) exp_ovr++;
  endtask

  // Feed pairs until the model holds 'target' of them.
  task automatic fill_frame(input int target, input bit toggle, input bit ramp);
    int cyc = 0;
    logic [31:0] d;
    while (model_q.size() < target) begin
      if (cyc > 3 * FL) begin
        chk("fill_timeout", model_q.size(), target);
        break;
      end
      chk("fill_ready", in_ready, 1);
      chk("fill_start", start, 0);
      chk("fill_sv", stream_valid, 0);
      chk("fill_busy", busy, 0);
      if (ramp) d = {16'(model_q.size()), ~16'(model_q.size())};
      else      d = $urandom;
      in_valid = toggle ? ~cyc[0] : 1'b1;
      in_m0 = d[31:16];
      in_m1 = d[15:0];
      flush = 1'b0;
      cc_done = 1'($urandom_range(0, 1));
      tick();
      if (in_valid) model_q.push_back(d);
      cyc++;
    end
    $display("fill: %0d pairs accepted in %0d cycles", model_q.size(), cyc);
  endtask

  // Check START and the stream; abort_at >= 0 resets at that sample.
  task automatic stream_frame(input int abort_at, input bit hold_valid);
    logic [31:0] w;
    chk("start_pulse", start, 1);
    chk("start_busy", busy, 1);
    chk("start_ready", in_ready, 0);
    chk("start_sv", stream_valid, 0);
    frame = model_q;
    model_q.delete();
    cc_done = 1'b1;
    drive_idle(hold_valid);
    tick();
    for (int k = 0; k < FL; k++) begin
      w = frame[k];
      chk("stream_sv", stream_valid, 1);
      chk("stream_m0", m0, w[31:16]);
      chk("stream_m1", m1, w[15:0]);
      chk("stream_start", start, 0);
      chk("stream_ready", in_ready, 0);
      if (k == abort_at) begin
        $display("stream: reset at sample %0d", k);
        do_reset();
        return;
      end
      drive_idle(hold_valid);
      tick();
    end
    chk("end_sv", stream_valid, 0);
    chk("end_m0", m0, 0);
    chk("end_m1", m1, 0);
    chk("end_busy", busy, 1);
    $display("stream: %0d samples checked", FL);
  endtask

  // Stay in WAIT_DONE for pulse_at cycles, then pulse cc_done.
  task automatic wait_phase(input int pulse_at, input bit hold10);
    for (int w = 0; w < pulse_at; w++) begin
      chk("wait_busy", busy, 1);
      chk("wait_ready", in_ready, 0);
      chk("wait_sv", stream_valid, 0);
      cc_done = 1'b0;
      in_valid = (hold10 && w < 10) ? 1'b1 : 1'b0;
      flush = 1'($urandom_range(0, 1));
      if (in_valid && exp_ovr < 65535) exp_ovr++;
      tick();
    end
    chk("wait_ready_pre", in_ready, 0);
    cc_done = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    tick();
    cc_done = 1'b0;
    chk("done_ready", in_ready, 1);
    chk("done_busy", busy, 0);
    $display("wait: cc_done pulsed at cycle %0d, in_ready=%0b", pulse_at, in_ready);
  endtask

  initial begin
    do_reset();

    // Frame 1: ramp data, in_valid held through START/STREAM/10 wait cycles.
    fill_frame(FL, 1'b0, 1'b1);
    stream_frame(-1, 1'b1);
    wait_phase(500, 1'b1);
`ifdef CC_FEEDER_OVERRUN_EN
    chk("ovr_12811", overrun_cnt, 12811);
`endif
    chk_ovr("ovr_frame1");

    // Frame 2: 100 pairs, flush with in_valid, toggled refill, reset mid-stream.
    fill_frame(100, 1'b0, 1'b0);
    chk("flush_ready", in_ready, 1);
    in_valid = 1'b1;
    flush = 1'b1;
    in_m0 = 16'($urandom);
    in_m1 = 16'($urandom);
    tick();
    flush = 1'b0;
    model_q.delete();
    $display("flush: partial frame discarded");
    fill_frame(FL, 1'b1, 1'b0);
    stream_frame(6000, 1'b0);

    // Frame 3: a full refill must be needed after the aborted frame.
    fill_frame(FL, 1'b0, 1'b0);
    stream_frame(-1, 1'b0);
    wait_phase(3, 1'b0);
    chk_ovr("ovr_frame3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
